// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
//
// Load/store responder between the execute stage and the data-memory bus.
// Accepts a 4-bit memory-op code, runs one req/ack transaction at a time,
// steers store bytes onto their lanes with matching byte enables, and
// sign/zero-extends load results. Holds the core stalled while busy.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses skip the bus and pulse
//               `misaligned` in DONE.
//   undefined : `misaligned` is tied 0; low address bits are simply ignored.
//
// Parameters
//   TIMEOUT     cycles to wait for bus_ack in REQ before aborting.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   mem_write   [3:0]       op: 0 none,1 SW,2 SH,3 SB,4 LW,5 LH,6 LB,7 LBU,8 LHU
//   alu_result  [31:0]      byte address
//   write_data  [31:0]      store data
//   read_data   [31:0]      extended load result (valid in DONE, then held)
//   stall                   pipeline hold (combinational)
//   bus_err                 one-cycle pulse in DONE after a timeout
//   misaligned              one-cycle pulse in DONE on a trapped access
//   bus_req/we/addr/wdata/be  data-memory bus request side
//   bus_rdata, bus_ack      data-memory bus response side
// -----------------------------------------------------------------------------
module data_mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_err,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Last REQ cycle before abort: the counter holds TIMEOUT-1 during it.
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

  localparam logic [3:0] OP_SW  = 4'd1;
  localparam logic [3:0] OP_SH  = 4'd2;
  localparam logic [3:0] OP_SB  = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LH  = 4'd5;
  localparam logic [3:0] OP_LB  = 4'd6;
  localparam logic [3:0] OP_LBU = 4'd7;
  localparam logic [3:0] OP_LHU = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state, state_d;
  logic [3:0]    op_q;
  logic [31:0]   addr_q;
  logic [CW-1:0] cnt;

  // Decode of the op currently presented by the execute stage.
  logic        valid_in;
  logic        we_in;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        mis_in;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_in = 1'b0;
    we_in    = 1'b0;
    be_in    = 4'b0000;
    wdata_in = write_data;
    unique case (mem_write)
      OP_SW, OP_LW: begin
        valid_in = 1'b1;
        be_in    = 4'b1111;
      end
      OP_SH, OP_LH, OP_LHU: begin
        valid_in = 1'b1;
        be_in    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{write_data[15:0]}};
      end
      OP_SB, OP_LB, OP_LBU: begin
        valid_in = 1'b1;
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{write_data[7:0]}};
      end
      default: ;
    endcase
    we_in = (mem_write == OP_SW) || (mem_write == OP_SH) || (mem_write == OP_SB);
    // Loads carry no store data on the bus lanes of interest; keep raw value.
    if (!we_in) wdata_in = write_data;
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    mis_in = 1'b0;
    unique case (mem_write)
      OP_SW, OP_LW:         mis_in = (alu_result[1:0] != 2'b00);
      OP_SH, OP_LH, OP_LHU: mis_in = alu_result[0];
      default: ;
    endcase
  end
`else
  assign mis_in = 1'b0;
`endif

  // Load extraction from the returned word using the latched address/op.
  logic [31:0] rdata_shifted;
  logic [15:0] rdata_half;
  logic [31:0] load_ext;

  assign rdata_shifted = bus_rdata >> {addr_q[1:0], 3'b000};
  assign rdata_half    = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    load_ext = bus_rdata;
    unique case (op_q)
      OP_LH:   load_ext = {{16{rdata_half[15]}}, rdata_half};
      OP_LHU:  load_ext = {16'h0000, rdata_half};
      OP_LB:   load_ext = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      OP_LBU:  load_ext = {24'h000000, rdata_shifted[7:0]};
      default: load_ext = bus_rdata;
    endcase
  end

  wire timeout_hit = (cnt == TIMEOUT_LAST);

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (valid_in) state_d = mis_in ? S_DONE : S_REQ;
      S_REQ:  if (bus_ack || timeout_hit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= 4'd0;
      addr_q    <= 32'd0;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'd0;
      read_data <= 32'd0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          cnt <= '0;
          if (valid_in) begin
            op_q      <= mem_write;
            addr_q    <= alu_result;
            bus_we    <= we_in;
            bus_be    <= be_in;
            bus_wdata <= wdata_in;
          end
        end
        S_REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ack) begin
            // Ack wins over a simultaneous timeout; stores keep read_data.
            if (!bus_we) read_data <= load_ext;
          end else if (timeout_hit) begin
            bus_err   <= 1'b1;
            read_data <= 32'd0;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misaligned_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) misaligned_q <= 1'b0;
    else       misaligned_q <= (state == S_IDLE) && valid_in && mis_in;
  end
  assign misaligned = misaligned_q;
`else
  assign misaligned = 1'b0;
`endif

  // Decoded straight from state so reset drops the request asynchronously.
  assign bus_req  = (state == S_REQ);
  assign bus_addr = {addr_q[31:2], 2'b00};
  assign stall    = ((state == S_IDLE) && valid_in) || (state == S_REQ);

endmodule

// File: tb/tb_data_mem_access_unit.sv
module tb_data_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_write;
  logic [31:0] alu_result, write_data, read_data;
  logic        stall, bus_err, misaligned, bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] last_rd;

  data_mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .alu_result(alu_result),
    .write_data(write_data), .read_data(read_data), .stall(stall),
    .bus_err(bus_err), .misaligned(misaligned), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          n;       // REQ cycle (1-based) in which ack arrives
    logic        we;
    logic [3:0]  be;
    logic [31:0] exp_wd;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    mem_write = v.op; alu_result = v.addr; write_data = v.wd; bus_ack = 1'b0;
    #1 check({tag, "_stall_issue"}, 32'(stall), 32'd1);
    @(negedge clk);
    mem_write = 4'd0;
    check({tag, "_req"},   32'(bus_req), 32'd1);
    check({tag, "_addr"},  bus_addr, v.exp_addr);
    check({tag, "_we"},    32'(bus_we), 32'(v.we));
    check({tag, "_be"},    32'(bus_be), 32'(v.be));
    check({tag, "_wdata"}, bus_wdata, v.exp_wd);
    for (int k = 1; k < v.n; k++) begin
      @(negedge clk);
      check({tag, "_req_wait"}, 32'(bus_req), 32'd1);
    end
    bus_ack = 1'b1; bus_rdata = v.rdata;
    check({tag, "_stall_ack"}, 32'(stall), 32'd1);
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    if (!v.we) last_rd = v.exp_rd;
    check({tag, "_done_stall"}, 32'(stall), 32'd0);
    check({tag, "_done_req"},   32'(bus_req), 32'd0);
    check({tag, "_done_err"},   32'(bus_err), 32'd0);
    check({tag, "_read_data"},  read_data, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    //            op     addr          wd            rdata        n  we be       exp_wd        exp_addr      exp_rd
    vecs[0]  = '{4'd1, 32'h100, 32'hDEADBEEF, 32'h0,        2, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h100, 32'h0};
    vecs[1]  = '{4'd3, 32'h103, 32'h000000A5, 32'h0,        1, 1'b1, 4'b1000, 32'hA5A5A5A5, 32'h100, 32'h0};
    vecs[2]  = '{4'd2, 32'h102, 32'h1234ABCD, 32'h0,        3, 1'b1, 4'b1100, 32'hABCDABCD, 32'h100, 32'h0};
    vecs[3]  = '{4'd6, 32'h102, 32'h0,        32'h12805634, 1, 1'b0, 4'b0100, 32'h0,        32'h100, 32'hFFFFFF80};
    vecs[4]  = '{4'd7, 32'h102, 32'h0,        32'h12805634, 1, 1'b0, 4'b0100, 32'h0,        32'h100, 32'h00000080};
    vecs[5]  = '{4'd5, 32'h102, 32'h0,        32'h12805634, 2, 1'b0, 4'b1100, 32'h0,        32'h100, 32'h00001280};
    vecs[6]  = '{4'd8, 32'h100, 32'h0,        32'h7777F00D, 1, 1'b0, 4'b0011, 32'h0,        32'h100, 32'h0000F00D};
    vecs[7]  = '{4'd3, 32'h101, 32'h0000005A, 32'h0,        2, 1'b1, 4'b0010, 32'h5A5A5A5A, 32'h100, 32'h0};
    vecs[8]  = '{4'd5, 32'h100, 32'h0,        32'h7777F00D, TO, 1'b0, 4'b0011, 32'h0,       32'h100, 32'hFFFFF00D};
    vecs[9]  = '{4'd4, 32'h104, 32'h0,        32'hCAFEF00D, 1, 1'b0, 4'b1111, 32'h0,        32'h104, 32'hCAFEF00D};
    vecs[10] = '{4'd4, 32'h101, 32'h0,        32'h11223344, 2, 1'b0, 4'b1111, 32'h0,        32'h100, 32'h11223344};
    vecs[11] = '{4'd6, 32'h101, 32'h0,        32'h0000FF00, 3, 1'b0, 4'b0010, 32'h0,        32'h100, 32'hFFFFFFFF};
    vecs[12] = '{4'd7, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 4'b1000, 32'h0,        32'h100, 32'h00000080};

    reset = 1'b1; mem_write = 4'd0; alu_result = 32'h0; write_data = 32'h0;
    bus_rdata = 32'h0; bus_ack = 1'b0; last_rd = 32'h0;
    #12;
    check("rst_req", 32'(bus_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_be", 32'(bus_be), 32'd0);
    check("rst_rd", read_data, 32'h0);
    check("rst_err", 32'(bus_err), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

    // Reset during REQ: request drops at once, late ack ignored.
    @(negedge clk);
    mem_write = 4'd4; alu_result = 32'h300;
    @(negedge clk);
    mem_write = 4'd0;
    check("mid_req_before", 32'(bus_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_req", 32'(bus_req), 32'd0);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_addr", bus_addr, 32'h0);
    check("mid_rst_be", 32'(bus_be), 32'd0);
    check("mid_rst_rd", read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    check("late_ack_req", 32'(bus_req), 32'd0);
    check("late_ack_rd", read_data, 32'h0);
    check("late_ack_err", 32'(bus_err), 32'd0);
    last_rd = 32'h0;

    // Timeout: no ack, bus_req for exactly TO cycles, then bus_err pulse.
    // Preload read_data so the forced zero is observable.
    run_vec(100, vecs[9]);
    @(negedge clk);
    mem_write = 4'd4; alu_result = 32'h200;
    @(negedge clk);
    mem_write = 4'd0;
    req_cycles = 0;
    for (int i = 0; i < 10 && bus_req; i++) begin
      req_cycles++;
      @(negedge clk);
    end
    check("to_req_cycles", 32'(req_cycles), 32'(TO));
    check("to_err", 32'(bus_err), 32'd1);
    check("to_rd", read_data, 32'h0);
    check("to_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(bus_err), 32'd0);

    // Invalid codes and stray ack in IDLE do nothing.
    mem_write = 4'd9;
    #1 check("op9_stall", 32'(stall), 32'd0);
    @(negedge clk);
    mem_write = 4'd15; bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    check("op9_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0; mem_write = 4'd0;
    check("op15_req", 32'(bus_req), 32'd0);
    check("idle_ack_rd", read_data, 32'h0);

    // Op held through DONE: not re-launched in DONE, re-accepted in next IDLE.
    mem_write = 4'd3; alu_result = 32'h102; write_data = 32'h00000011;
    @(negedge clk);
    check("hold_req1", 32'(bus_req), 32'd1);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("hold_done_stall", 32'(stall), 32'd0);
    check("hold_done_req", 32'(bus_req), 32'd0);
    @(negedge clk);
    check("hold_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    mem_write = 4'd0;
    check("hold_req2", 32'(bus_req), 32'd1);
    check("hold_be2", 32'(bus_be), 32'b0100);
    check("hold_wd2", bus_wdata, 32'h11111111);
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    check("hold_done2_rd", read_data, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_access_unit.md
# data_mem_access_unit

Load/store responder for the RISC-V core: consumes the 4-bit memory-operation code produced by the control unit, the ALU-computed address and the store data, and runs a single outstanding req/ack transaction on the data-memory bus. Performs byte-lane steering and write-strobe generation for stores, and sign/zero extension for loads. Stalls the core while a transaction is in flight. Sits between the execute stage and the external data memory.

## Interface

- TIMEOUT, 255: max cycles waiting for bus_ack in REQ before abort; counter width = $clog2(TIMEOUT+1).
- clk  input  1  core clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_write  input  4  op code: 0 none, 1 SW, 2 SH, 3 SB, 4 LW, 5 LH, 6 LB, 7 LBU, 8 LHU; 9-15 treated as none.
- alu_result  input  32  byte address.
- write_data  input  32  store data (rs2).
- read_data  output  32  extended load result, valid in DONE.
- stall  output  1  holds core pipeline (combinational).
- bus_err  output  1  one-cycle pulse in DONE on timeout.
- misaligned  output  1  one-cycle pulse in DONE on misaligned access (macro-dependent).
- bus_req  output  1  transaction request.
- bus_we  output  1  1 store, 0 load.
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- bus_wdata  output  32  lane-replicated store data.
- bus_be  output  4  byte enables (loads and stores).
- bus_rdata  input  32  read word, sampled when bus_ack=1.
- bus_ack  input  1  completion, one cycle.

## Operation

- FSM states: IDLE, REQ, DONE. Reset -> IDLE.
- IDLE: valid op (1-8) -> latch code, address, data, be, wdata; go REQ (or DONE with misaligned, see Configuration). Else stay.
- REQ: bus_req=1, bus_addr/bus_we/bus_be/bus_wdata from latches, held stable until ack. bus_ack -> capture bus_rdata, go DONE. Timeout counter increments each REQ cycle; reaching TIMEOUT without ack -> DONE, bus_err=1, read_data=0, bus_req drops.
- DONE: one cycle, read_data valid, then IDLE unconditionally (the op still on mem_write is not re-launched).
- stall = (IDLE & valid op) | REQ. Low in DONE, during reset, and for code 0/9-15.
- Stores: SW be=1111, wdata=write_data. SH be=addr[1]?1100:0011, wdata={2{write_data[15:0]}}. SB be=0001<<addr[1:0], wdata={4{write_data[7:0]}}.
- Loads: be as for same-size store. LW word; LH/LHU halfword at addr[1]; LB/LBU byte at addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Store completion leaves read_data at previous value.

## Timing

- Reset values: bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_be 0, read_data 0, bus_err 0, misaligned 0, timeout counter 0; stall 0.
- Reset mid-transaction: immediate return to IDLE, bus_req drops asynchronously; in-flight ack afterwards ignored.
- Latency: op seen cycle 0 (IDLE), bus_req from cycle 1; ack in cycle N (N≥1) -> DONE cycle N+1. Minimum 3 cycles/access, stall high cycles 0..N.
- Back-to-back accesses: next op accepted in IDLE cycle after DONE.
- Ack in the same cycle counter reaches TIMEOUT: ack wins, no bus_err.
- bus_ack outside REQ ignored.

## Configuration

- LSU_MISALIGN_TRAP_EN defined: SH/LH/LHU with addr[0]=1, SW/LW with addr[1:0]≠0 -> no bus transaction, IDLE->DONE directly, misaligned=1 in DONE, read_data unchanged, stall high for issue cycle only.
- Undefined: misaligned tied 0; halfword accesses use addr[1] only, word accesses ignore addr[1:0]; access proceeds normally.

## Test plan

- SW addr 0x100 data 0xDEADBEEF, ack after 2 cycles -> bus_addr 0x100, be 1111, we 1, wdata 0xDEADBEEF, stall high 3 cycles.
- SB addr 0x103 data 0x000000A5 -> be 1000, wdata 0xA5A5A5A5.
- LB addr 0x102, rdata 0x12805634 -> read_data 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0x00001280.
- Load with no ack, TIMEOUT=4 -> bus_req 4 cycles, then DONE with bus_err=1, read_data 0, stall drops.
- LW addr 0x101 with LSU_MISALIGN_TRAP_EN -> no bus_req, misaligned pulse next cycle; without macro -> bus_addr 0x100, normal load.
- Assert reset during REQ -> bus_req 0 same cycle, state IDLE, all outputs at reset values; late ack ignored.
